// File: rtl/adc_scan_pkg.sv
// Shared constants, FSM encoding and channel search helper for the ADC scan scheduler.
package adc_scan_pkg;

  localparam int ADC_W       = 12;
  localparam int DEF_PERIOD  = 3117;
  localparam int DEF_TIMEOUT = 4096;
  localparam int MAX_CH      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_STORE,
    S_FINISH
  } state_t;

  // Lowest set bit of mask at index >= from; -1 when none remains.
  function automatic int find_ch(input logic [MAX_CH-1:0] mask, input int from);
    int r;
    r = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Free-running scan period counter: counts 0..PERIOD-1 while enabled, ticks on the last count.
module adc_period_timer
  import adc_scan_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || (cnt_q == LAST)) cnt_q <= '0;
    else                                   cnt_q <= cnt_q + CW'(1);
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Scan scheduler: turns period ticks and one-shot requests into per-channel SPI conversions.
// Optional conversion watchdog enabled by defining ADC_SCAN_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a pending request; snapshots mask/mode on start
// ISSUE     | waiting for engine idle, then pulses conv_start
// WAIT_DONE | conversion in flight, waiting for conv_done
// STORE     | result written; pick next channel or finish
// FINISH    | scan_done pulse active; busy drops on exit
module adc_scan_scheduler
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scan_en_i,
  input  logic [NUM_CH-1:0]       ch_mask_i,
  input  logic                    sgl_mode_i,
  input  logic                    oneshot_req_i,
  output logic                    conv_start_o,
  output logic [CH_W-1:0]         conv_ch_o,
  output logic                    conv_sgl_o,
  input  logic                    conv_busy_i,
  input  logic                    conv_done_i,
  input  logic [ADC_W-1:0]        conv_data_i,
  output logic [ADC_W*NUM_CH-1:0] res_data_o,
  output logic                    res_valid_o,
  output logic [CH_W-1:0]         res_ch_o,
  output logic                    scan_done_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_err_o
);

  state_t                       state_q;
  logic                         pending_q;
  logic [NUM_CH-1:0]            mask_q;
  logic [CH_W-1:0]              ch_q;
  logic [CH_W-1:0]              res_ch_q;
  logic [NUM_CH-1:0][ADC_W-1:0] res_q;
  logic conv_start_q, conv_sgl_q, res_valid_q, scan_done_q, busy_q, overrun_q;

  logic              tick;
  logic [MAX_CH-1:0] live_ext, snap_ext;
  int                first_idx, next_idx;

  adc_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (scan_en_i),
    .tick_o (tick)
  );

  always_comb begin
    live_ext = '0;
    snap_ext = '0;
    live_ext[NUM_CH-1:0] = ch_mask_i;
    snap_ext[NUM_CH-1:0] = mask_q;
    first_idx = find_ch(live_ext, 0);
    next_idx  = find_ch(snap_ext, int'(ch_q) + 1);
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      mask_q       <= '0;
      ch_q         <= '0;
      res_ch_q     <= '0;
      res_q        <= '0;
      conv_start_q <= 1'b0;
      conv_sgl_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      // Ticks landing mid-scan are dropped, only flagged.
      if (state_q != S_IDLE && tick) overrun_q <= 1'b1;
      if (state_q != S_IDLE && oneshot_req_i) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          pending_q <= !pending_q && (tick || oneshot_req_i);
          if (pending_q && (first_idx >= 0)) begin
            mask_q     <= ch_mask_i;
            conv_sgl_q <= sgl_mode_i;
            ch_q       <= CH_W'(first_idx);
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!conv_busy_i) begin
            conv_start_q <= 1'b1;
            state_q      <= S_WAIT_DONE;
`ifdef ADC_SCAN_TIMEOUT_EN
            tmo_q        <= TW'(TIMEOUT - 1);
`endif
          end
        end
        S_WAIT_DONE: begin
          if (conv_done_i) begin
            res_q[ch_q] <= conv_data_i;
            res_valid_q <= 1'b1;
            res_ch_q    <= ch_q;
            state_q     <= S_STORE;
          end
`ifdef ADC_SCAN_TIMEOUT_EN
          else if (tmo_q == '0) begin
            timeout_q <= 1'b1;
            if (next_idx >= 0) begin
              ch_q    <= CH_W'(next_idx);
              state_q <= S_ISSUE;
            end else begin
              scan_done_q <= 1'b1;
              state_q     <= S_FINISH;
            end
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
`endif
        end
        S_STORE: begin
          if (next_idx >= 0) begin
            ch_q    <= CH_W'(next_idx);
            state_q <= S_ISSUE;
          end else begin
            scan_done_q <= 1'b1;
            state_q     <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conv_start_o = conv_start_q;
  assign conv_ch_o    = ch_q;
  assign conv_sgl_o   = conv_sgl_q;
  assign res_data_o   = res_q;
  assign res_valid_o  = res_valid_q;
  assign res_ch_o     = res_ch_q;
  assign scan_done_o  = scan_done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

`ifdef ADC_SCAN_TIMEOUT_EN
  assign timeout_err_o = timeout_q;
`else
  // Watchdog compiled out: constant 0, written against TIMEOUT so the parameter stays referenced.
  assign timeout_err_o = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: stimulus pushes expected events, a monitor pops them.
module tb_adc_scan_scheduler;
  import adc_scan_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int P      = 3117;
  localparam int T      = 4096;

  logic        clk = 1'b0, rst = 1'b1;
  logic        scan_en = 1'b0, sgl_mode = 1'b0, oneshot = 1'b0;
  logic        conv_busy = 1'b0, conv_done = 1'b0;
  logic [1:0]  ch_mask = 2'b00;
  logic [11:0] conv_data = '0;

  logic            conv_start_o, conv_sgl_o, res_valid_o, scan_done_o, busy_o, overrun_o, timeout_err_o;
  logic [CH_W-1:0] conv_ch_o, res_ch_o;
  logic [23:0]     res_data_o;

  adc_scan_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD(P), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .scan_en_i(scan_en), .ch_mask_i(ch_mask),
    .sgl_mode_i(sgl_mode), .oneshot_req_i(oneshot),
    .conv_start_o(conv_start_o), .conv_ch_o(conv_ch_o), .conv_sgl_o(conv_sgl_o),
    .conv_busy_i(conv_busy), .conv_done_i(conv_done), .conv_data_i(conv_data),
    .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
    .scan_done_o(scan_done_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_START = 0, EV_RES = 1, EV_DONE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          ch;
    logic [11:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  start_log[$], res_log[$], done_log[$];
  int  checks = 0, failures = 0;
  int  cyc = 0;

  logic [11:0] eng_data[2];
  int          eng_delay[2];
  bit          eng_mute = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int ch, input logic [11:0] d);
    ev_t e;
    e.kind = k; e.ch = ch; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_scan2(input logic sgl, input logic [11:0] d0, input logic [11:0] d1);
    push(EV_START, 0, {11'd0, sgl}); push(EV_RES, 0, d0);
    push(EV_START, 1, {11'd0, sgl}); push(EV_RES, 1, d1);
    push(EV_DONE, 0, 12'd0);
  endtask

  task automatic see(input ev_kind_t k, input int ch, input logic [11:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind=%0d ch=%0d expected no event (cycle %0d)", k, ch, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    check("event_ch", ch, e.ch);
    check("event_data", {20'd0, d}, {20'd0, e.data});
  endtask

  // Monitor: every output pulse is matched against the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (conv_start_o) begin
        start_log.push_back(cyc);
        see(EV_START, int'(conv_ch_o), {11'd0, conv_sgl_o});
      end
      if (res_valid_o) begin
        res_log.push_back(cyc);
        see(EV_RES, int'(res_ch_o), res_data_o[int'(res_ch_o)*12 +: 12]);
      end
      if (scan_done_o) begin
        done_log.push_back(cyc);
        see(EV_DONE, 0, 12'd0);
      end
    end
  end

  // SPI engine model: conv_done eng_delay cycles after conv_start.
  initial forever begin
    int c;
    @(negedge clk);
    conv_done = 1'b0;
    if (!rst && conv_start_o && !eng_mute) begin
      c = int'(conv_ch_o);
      repeat (eng_delay[c] - 1) @(negedge clk);
      conv_done = 1'b1;
      conv_data = eng_data[c];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_log.delete(); res_log.delete(); done_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    exp_q.delete();
    clear_logs();
  endtask

  task automatic pulse_oneshot();
    oneshot = 1'b1;
    step();
    oneshot = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (done_log.size() < n && i < budget) begin
      step();
      i++;
    end
    if (done_log.size() < n) begin
      checks++; failures++;
      $display("FAIL %s: waited %0d cycles, got %0d scan_done expected %0d", name, budget, done_log.size(), n);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  int k, kf, s, n;
  bit any_busy;

  initial begin
    eng_data[0] = 12'hA5A; eng_data[1] = 12'h3C3;
    eng_delay[0] = 3;      eng_delay[1] = 3;
    do_reset();
    step();
    check("reset_outputs", {26'd0, conv_start_o, res_valid_o, scan_done_o, busy_o, overrun_o, timeout_err_o}, 32'd0);
    check("reset_res_data", {8'd0, res_data_o}, 32'd0);

    // Periodic two-channel scan.
    ch_mask = 2'b11; sgl_mode = 1'b1;
    push_scan2(1'b1, 12'hA5A, 12'h3C3);
    push_scan2(1'b1, 12'hA5A, 12'h3C3);
    k = cyc;
    scan_en = 1'b1;
    wait_done(2, 3 * P, "periodic_scans");
    scan_en = 1'b0;
    repeat (5) step();
    check("periodic_res_data", {8'd0, res_data_o}, 32'h003C3A5A);
    check("periodic_busy_low", {31'd0, busy_o}, 32'd0);
    check("periodic_overrun", {31'd0, overrun_o}, 32'd0);
    if (done_log.size() >= 2 && start_log.size() >= 2 && res_log.size() >= 2) begin
      check("first_start_latency", start_log[0] - k, P + 2);
      check("res_to_next_start", start_log[1] - res_log[0], 2);
      check("res_to_scan_done", done_log[0] - res_log[1], 1);
      check("scan_period", done_log[1] - done_log[0], P);
    end

    // One-shot on channel 1 only, periodic disabled.
    clear_logs();
    eng_data[1] = 12'h7E1;
    ch_mask = 2'b10; sgl_mode = 1'b0;
    push(EV_START, 1, 12'd0); push(EV_RES, 1, 12'h7E1); push(EV_DONE, 0, 12'd0);
    k = cyc;
    pulse_oneshot();
    step();
    check("oneshot_busy_up", {31'd0, busy_o}, 32'd1);
    wait_done(1, 100, "oneshot_scan");
    repeat (20) step();
    check("oneshot_start_count", start_log.size(), 1);
    if (start_log.size() >= 1) check("oneshot_start_latency", start_log[0] - k, 3);
    check("oneshot_res_data", {8'd0, res_data_o}, 32'h007E1A5A);
    check("oneshot_busy_low", {31'd0, busy_o}, 32'd0);

    // Engine busy for 50 cycles at scan start.
    clear_logs();
    eng_data[0] = 12'h155;
    ch_mask = 2'b01; conv_busy = 1'b1;
    push(EV_START, 0, 12'd0); push(EV_RES, 0, 12'h155); push(EV_DONE, 0, 12'd0);
    pulse_oneshot();
    repeat (49) step();
    check("held_no_start", start_log.size(), 0);
    kf = cyc;
    conv_busy = 1'b0;
    wait_done(1, 100, "busy_held_scan");
    if (start_log.size() >= 1) check("start_after_busy_drop", start_log[0] - kf, 1);
    check("busy_held_res_data", {8'd0, res_data_o}, 32'h007E1155);

    // Slow conversion spans the next tick: overrun, no extra scan.
    clear_logs();
    eng_data[0] = 12'h0F0; eng_data[1] = 12'h00F;
    eng_delay[0] = P + 50;
    ch_mask = 2'b11; sgl_mode = 1'b1;
    push_scan2(1'b1, 12'h0F0, 12'h00F);
    scan_en = 1'b1;
    repeat (P + 10) step();
    check("overrun_before_tick", {31'd0, overrun_o}, 32'd0);
    wait_done(1, 2 * P, "overrun_scan");
    scan_en = 1'b0;
    repeat (30) step();
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    check("overrun_start_count", start_log.size(), 2);
    check("overrun_done_count", done_log.size(), 1);
    check("overrun_res_data", {8'd0, res_data_o}, 32'h0000F0F0);
    eng_delay[0] = 3;

    // Empty mask: request swallowed silently.
    clear_logs();
    ch_mask = 2'b00;
    any_busy = 1'b0;
    pulse_oneshot();
    repeat (20) begin
      step();
      any_busy |= busy_o;
    end
    check("empty_mask_busy", {31'd0, any_busy}, 32'd0);
    check("empty_mask_starts", start_log.size(), 0);
    check("empty_mask_done", done_log.size(), 0);
    check("overrun_sticky", {31'd0, overrun_o}, 32'd1);

    do_reset();
    step();
    check("reset_clears_overrun", {31'd0, overrun_o}, 32'd0);
    check("reset_clears_res", {8'd0, res_data_o}, 32'd0);

`ifdef ADC_SCAN_TIMEOUT_EN
    // Silent engine: watchdog fires and the scan moves on.
    eng_mute = 1'b1;
    ch_mask = 2'b11; sgl_mode = 1'b1;
    push(EV_START, 0, 12'd1); push(EV_START, 1, 12'd1);
    pulse_oneshot();
    n = 0;
    while (start_log.size() == 0 && n < 50) begin
      step();
      n++;
    end
    check("tmo_first_start", start_log.size(), 1);
    if (start_log.size() >= 1) begin
      s = start_log[0];
      while (cyc < s + T - 1) step();
      check("tmo_not_yet", {31'd0, timeout_err_o}, 32'd0);
      step();
      check("tmo_set", {31'd0, timeout_err_o}, 32'd1);
      step();
      check("tmo_next_start", {30'd0, conv_start_o, conv_ch_o}, 32'd3);
    end
    repeat (50) step();
    check("tmo_no_result", res_log.size(), 0);
    do_reset();
    step();
    check("tmo_reset_err", {31'd0, timeout_err_o}, 32'd0);
    check("tmo_reset_outs", {26'd0, conv_start_o, res_valid_o, scan_done_o, busy_o, overrun_o, timeout_err_o}, 32'd0);
    eng_mute = 1'b0;
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Conversion scheduler for the 12-bit SPI ADC front-end. It turns a periodic sample tick and software one-shot requests into an ordered sequence of single-channel conversion commands for the SPI engine. It collects each returned word into a per-channel result register. It sits between the SPI engine and the downstream DSP/display logic, owns the engine's start handshake, and is the only block allowed to issue conversions.

## Interface
- NUM_CH, 2: number of ADC input channels scanned
- CH_W, $clog2(NUM_CH) (min 1): channel index width
- PERIOD, 3117: clk cycles between periodic scan starts (matches the SPI frame period)
- TIMEOUT, 4096: max clk cycles to wait for conv_done (used only with the macro)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- scan_en  in  1  enables periodic scanning
- ch_mask  in  NUM_CH  channel enable, bit i = channel i
- sgl_mode  in  1  1 = single-ended, 0 = differential; forwarded to the engine
- oneshot_req  in  1  one-cycle pulse requesting one scan
- conv_start  out  1  one-cycle pulse to the SPI engine
- conv_ch  out  CH_W  channel for the current conversion; stable from conv_start until conv_done
- conv_sgl  out  1  mode bit latched with conv_ch
- conv_busy  in  1  SPI engine busy
- conv_done  in  1  one-cycle pulse; conv_data valid in the same cycle
- conv_data  in  12  conversion result
- res_data  out  12*NUM_CH  result registers; channel i at [12i+11:12i]
- res_valid  out  1  one-cycle pulse when a result register updates
- res_ch  out  CH_W  channel of the update flagged by res_valid
- scan_done  out  1  one-cycle pulse after the last channel of a scan
- busy  out  1  high from scan start until scan_done
- overrun  out  1  sticky; a periodic tick arrived while a scan was active
- timeout_err  out  1  sticky; the engine failed to complete a conversion

## Operation
- Period timer:
  - Counts 0..PERIOD-1 while scan_en=1 and emits a tick at PERIOD-1, then wraps to 0.
  - Holds at 0 while scan_en=0.
- Request latch: a tick or oneshot_req sets `pending`. Tick and oneshot in the same cycle produce one scan.
- FSM states: IDLE, ISSUE, WAIT_DONE, STORE, FINISH.
- IDLE:
  - If pending, snapshot ch_mask and sgl_mode, clear pending, select the lowest enabled channel, assert busy, and go to ISSUE.
  - If the snapshot mask is all-zero, clear pending, stay in IDLE, and issue nothing (no scan_done).
- ISSUE: when conv_busy=0, pulse conv_start for one cycle and go to WAIT_DONE. Otherwise hold in ISSUE.
- WAIT_DONE: on conv_done, write conv_data into the slot for conv_ch and go to STORE. conv_done in any other state is ignored.
- STORE:
  - Pulse res_valid with res_ch.
  - If a higher enabled channel remains in the snapshot, go to ISSUE with the next channel, in ascending order.
  - Otherwise go to FINISH.
- FINISH: pulse scan_done, deassert busy, and go to IDLE.
- During a scan:
  - A tick sets overrun and is dropped (not latched).
  - oneshot_req sets pending, which is served after FINISH.
- ch_mask and sgl_mode changes mid-scan have no effect until the next scan.
- Reset:
  - All outputs go to 0, including res_data, overrun and timeout_err. The timer, pending and FSM clear.
  - Reset during a conversion aborts it with no res_valid. The SPI engine is reset by the same rst.

## Timing
- Latency, IDLE with pending and conv_busy=0: IDLE → ISSUE takes 1 cycle, and conv_start is asserted in the following cycle.
- conv_done at edge N: res_data updates at edge N. res_valid is high during the cycle after edge N.
- Next conv_start follows res_valid by 2 cycles (STORE→ISSUE, ISSUE issues), assuming conv_busy=0.
- scan_done pulses the cycle after the last res_valid. busy falls at the same edge that ends scan_done.
- The minimum spacing between scans is 1 IDLE cycle.

## Configuration
- ADC_SCAN_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE. After TIMEOUT cycles without conv_done, timeout_err is set (sticky until rst).
  - The channel's result is left unchanged, there is no res_valid, and the FSM advances as if from STORE.
- Not defined: WAIT_DONE waits indefinitely, and timeout_err is tied to 0.

## Structure
- Package adc_scan_pkg holds:
  - ADC_W=12
  - the FSM state encoding
  - default PERIOD and TIMEOUT constants
- Sub-module adc_period_timer: the PERIOD counter with enable and a one-cycle tick output.
- The next-channel search (lowest set bit above the current index in the mask snapshot) is a function in the package.

## Test plan
- scan_en=1, ch_mask=2'b11, the engine model returns 12'hA5A on ch0 and 12'h3C3 on ch1:
  - conv_start fires for ch0 then ch1.
  - res_data = {12'h3C3, 12'hA5A}.
  - scan_done fires once per PERIOD.
- ch_mask=2'b10 with a oneshot_req pulse, scan_en=0: one conversion on ch1 only, res_ch=1, then scan_done. No further starts.
- conv_busy held high for 50 cycles at scan start: conv_start appears exactly 1 cycle after conv_busy falls.
- Engine model delays conv_done past the next tick: overrun=1, and no extra scan starts.
- ch_mask=0 with oneshot_req: no conv_start, no scan_done, and busy stays 0.
- With ADC_SCAN_TIMEOUT_EN and an engine that never sends conv_done:
  - After TIMEOUT cycles timeout_err=1 and the next channel is issued.
  - rst mid-wait clears timeout_err and all outputs.
